calc_step_sequencer: RTL and testbench

- Multi-cycle operation sequencer for the 16-bit signed calculator datapath.
- Accepts a start request with a step count N.
- Drives the datapath through one load cycle, then N step cycles, then a one-cycle done pulse.
- Owns and controls an internal flex counter (clear / count_enable / rollover_val) that supplies the step index.

---
 rtl/calc_pkg.sv | 6 +
 rtl/flex_counter.sv | 39 +++
 rtl/calc_step_sequencer.sv | 74 +++++++
 tb/tb_calc_step_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator step sequencer.
package calc_pkg;
  localparam int SEQ_CNT_WIDTH = 5;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;
endpackage

// File: rtl/flex_counter.sv
// Up counter with sync clear that wraps to 1 after reaching rollover_val.
module flex_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] next_count;
  logic             next_flag;

  always_comb begin
    next_count = count_out;
    next_flag  = rollover_flag;
    if (clear) begin
      next_count = '0;
      next_flag  = 1'b0;
    end else if (count_enable) begin
      next_count = (count_out == rollover_val) ? ONE : count_out + ONE;
      next_flag  = (next_count == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end
endmodule

// File: rtl/calc_step_sequencer.sv
// Load / N-step / done sequencer for the calculator datapath; step index
// comes from a flex counter that is held clear outside RUN.
module calc_step_sequencer
  import calc_pkg::*;
#(
  parameter int CNT_WIDTH = SEQ_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] op_cycles,
  input  logic                 abort,
  output logic                 busy,
  output logic                 load,
  output logic                 step_en,
  output logic [CNT_WIDTH-1:0] step_idx,
  output logic                 done,
  output logic                 err
);
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t           state;
  logic [CNT_WIDTH-1:0] cycles_reg;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_roll;
  logic                 last_step;

  flex_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state != RUN),
    .count_enable (state == RUN),
    .rollover_val (cycles_reg),
    .count_out    (cnt),
    .rollover_flag(cnt_roll)
  );

  // rollover_val = N is never reached inside RUN; the flag is only a backstop.
  assign last_step = (cnt == cycles_reg - ONE) || cnt_roll;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cycles_reg <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (op_cycles != '0) begin
            cycles_reg <= op_cycles;
            err        <= 1'b0;
            state      <= LOAD;
          end else begin
            err   <= 1'b1;
            state <= DONE;
          end
        end
        LOAD: state <= abort ? IDLE : RUN;
        RUN: begin
          if (abort)          state <= IDLE;
          else if (last_step) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == LOAD) || (state == RUN);
  assign load     = (state == LOAD);
  assign step_en  = (state == RUN);
  assign step_idx = (state == RUN) ? cnt : '0;
  assign done     = (state == DONE);
endmodule

// File: tb/tb_calc_step_sequencer.sv
// Scoreboard bench for calc_step_sequencer: a plan-queue model predicts each
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_calc_step_sequencer;
  localparam int W = 5;

  typedef struct packed {
    logic         busy;
    logic         load;
    logic         step_en;
    logic [W-1:0] idx;
    logic         done;
  } ob_t;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_cycles = '0;
  logic         abort = 1'b0;
  logic         busy, load, step_en, done, err;
  logic [W-1:0] step_idx;

  int n_checks = 0;
  int n_fail   = 0;

  ob_t        plan[$];
  ob_t        cur = '0;
  bit         err_m = 1'b0;
  logic [9:0] exp_q[$];

  calc_step_sequencer #(.CNT_WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .op_cycles(op_cycles),
    .abort(abort), .busy(busy), .load(load), .step_en(step_en),
    .step_idx(step_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic ob_t mk(bit b, bit l, bit s, logic [W-1:0] i, bit d);
    ob_t o;
    o.busy = b; o.load = l; o.step_en = s; o.idx = i; o.done = d;
    return o;
  endfunction

  // Reference: an accepted request expands into its whole output schedule.
  task automatic model_step(input bit s, input logic [W-1:0] n, input bit a);
    if (cur.busy && a) begin
      plan.delete();
      cur = '0;
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else if (!cur.busy && !cur.done && s) begin
      if (n == 0) begin
        err_m = 1'b1;
        cur = mk(0, 0, 0, '0, 1);
      end else begin
        err_m = 1'b0;
        cur = mk(1, 1, 0, '0, 0);
        for (int i = 0; i < int'(n); i++) plan.push_back(mk(1, 0, 1, W'(i), 0));
        plan.push_back(mk(0, 0, 0, '0, 1));
      end
    end else begin
      cur = '0;
    end
    exp_q.push_back({cur, err_m});
  endtask

  task automatic cycle(input bit s, input logic [W-1:0] n, input bit a);
    start = s; op_cycles = n; abort = a;
    @(posedge clk);
    model_step(s, n, a);
    #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({busy, load, step_en, step_idx, done, err} != 10'd0) begin
      n_fail++;
      $display("FAIL %s got=%b want=0", name, {busy, load, step_en, step_idx, done, err});
    end
  endtask

  // Monitor: every scheduled cycle is compared at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [9:0] e, g;
        e = exp_q.pop_front();
        g = {busy, load, step_en, step_idx, done, err};
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t got b/l/s/idx/d/e=%b want=%b", $time, g, e);
        end
      end
    end
  end

  initial begin
    #1 check_zero("reset_async");
    #6 n_rst = 1'b1;
    repeat (5) cycle(0, '0, 0);

    // N=4 nominal run
    cycle(1, 5'd4, 0);
    repeat (7) cycle(0, '0, 0);

    // N=1 twice, second start one cycle after done
    cycle(1, 5'd1, 0);
    repeat (3) cycle(0, '0, 0);
    cycle(1, 5'd1, 0);
    repeat (4) cycle(0, '0, 0);

    // zero-length request, sticky err, cleared by N=3
    cycle(1, 5'd0, 0);
    repeat (3) cycle(0, '0, 0);
    cycle(1, 5'd3, 0);
    repeat (6) cycle(0, '0, 0);

    // N=6: start during step 1 ignored, abort during step 2
    cycle(1, 5'd6, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    cycle(1, 5'd5, 0);
    cycle(0, '0, 1);
    repeat (4) cycle(0, '0, 0);

    // start while DONE is displayed must be ignored
    cycle(1, 5'd2, 0);
    repeat (3) cycle(0, '0, 0);
    cycle(1, 5'd2, 0);
    repeat (3) cycle(0, '0, 0);

    // full-length run
    cycle(1, 5'd31, 0);
    repeat (34) cycle(0, '0, 0);

    // async reset at step 10 of a 20-step run
    cycle(1, 5'd20, 0);
    repeat (11) cycle(0, '0, 0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_zero("reset_mid_run");
    plan.delete(); cur = '0; err_m = 1'b0; exp_q.delete();
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    repeat (5) cycle(0, '0, 0);

    // randomized traffic with stray starts and aborts
    for (int t = 0; t < 60; t++) begin
      int guard;
      logic [W-1:0] n;
      n = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 31));
      cycle(1, n, 0);
      guard = 0;
      while ((cur.busy || cur.done || plan.size() > 0) && guard < 40) begin
        cycle($urandom_range(0, 3) == 0, W'($urandom_range(0, 31)), $urandom_range(0, 24) == 0);
        guard++;
      end
      n_checks++;
      if (guard >= 40) begin
        n_fail++;
        $display("FAIL model_drain guard=%0d want<40", guard);
      end
      repeat ($urandom_range(0, 2)) cycle(0, '0, 0);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
